// File: rtl/dq_pkg.sv
// Shared number formats for the quantize/dequantize pair: Q4.3 storage lanes
// expand exactly to Q17.6 accumulator elements.
package dq_pkg;

    localparam int Q_DW  = 8;
    localparam int Q_PC  = 3;
    localparam int A_DW  = 24;
    localparam int A_PC  = 6;
    localparam int LANES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } dq_state_e;

    // Width of a lane-count field able to hold 0..lanes.
    function automatic int dq_cnt_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/dequant_unpack_if.sv
// Packed-word input stream and expanded-element output stream of the unpacker.
// slave is the unpacker's view, master is the producer/consumer view.
interface dequant_unpack_if #(
    parameter int Q_DW  = dq_pkg::Q_DW,
    parameter int A_DW  = dq_pkg::A_DW,
    parameter int LANES = dq_pkg::LANES
) ();

    localparam int CW = dq_pkg::dq_cnt_w(LANES);

    logic                  s_valid;
    logic                  s_ready;
    logic [LANES*Q_DW-1:0] s_data;
    logic [CW-1:0]         s_cnt;
    logic                  s_last;

    logic                  m_valid;
    logic                  m_ready;
    logic [A_DW-1:0]       m_data;
    logic                  m_last;

    modport slave (
        input  s_valid, s_data, s_cnt, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, s_cnt, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

endinterface

// File: rtl/dequant_lane.sv
// Exact signed fixed-point widening of one lane: sign-extend, then align the
// binary point. Purely combinational, no handshake.
module dequant_lane #(
    parameter int Q_DW = dq_pkg::Q_DW,
    parameter int Q_PC = dq_pkg::Q_PC,
    parameter int A_DW = dq_pkg::A_DW,
    parameter int A_PC = dq_pkg::A_PC
) (
    input  logic [Q_DW-1:0] q_i,
    output logic [A_DW-1:0] a_o
);

    localparam int SH = A_PC - Q_PC;

    logic [A_DW-1:0] ext;

    assign ext = {{(A_DW - Q_DW){q_i[Q_DW-1]}}, q_i};
    assign a_o = ext << SH;

endmodule

// File: rtl/dequant_unpack.sv
// Unpacks LANES quantized lanes per word into one widened element per cycle;
// 1-cycle latency, registered outputs hold under m_ready low, zero-bubble reload.
module dequant_unpack #(
    parameter int Q_DW  = dq_pkg::Q_DW,
    parameter int Q_PC  = dq_pkg::Q_PC,
    parameter int A_DW  = dq_pkg::A_DW,
    parameter int A_PC  = dq_pkg::A_PC,
    parameter int LANES = dq_pkg::LANES
) (
    input  logic            clk,
    input  logic            rst_n,
    dequant_unpack_if.slave bus
);

    import dq_pkg::dq_state_e;
    import dq_pkg::IDLE;
    import dq_pkg::EMIT;

    localparam int CW = dq_pkg::dq_cnt_w(LANES);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    dq_state_e             state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic [LANES*Q_DW-1:0] word_q, word_d;
    logic                  m_valid_q;
    logic [A_DW-1:0]       m_data_q;
    logic                  m_last_q, m_last_d;
    logic                  live_q;

    logic                  out_xfer;
    logic                  in_xfer;
    logic                  at_last;
    logic                  s_ready;
    logic                  load;
    logic [CW-1:0]         eff_cnt;
    logic [Q_DW-1:0]       lane_q;
    logic [A_DW-1:0]       lane_a;

    assign eff_cnt  = ((bus.s_cnt == '0) || (bus.s_cnt > CW'(LANES))) ? CW'(LANES) : bus.s_cnt;
    assign out_xfer = m_valid_q && bus.m_ready;
    assign at_last  = (CW'(idx_q) == (cnt_q - CW'(1)));
    // live_q keeps s_ready low through reset and until the first edge after release
    assign s_ready  = live_q && ((state_q == IDLE) || (out_xfer && at_last));
    assign in_xfer  = bus.s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        word_d  = word_q;
        load    = 1'b0;
        if (in_xfer) begin
            state_d = EMIT;
            word_d  = bus.s_data;
            cnt_d   = eff_cnt;
            last_d  = bus.s_last;
            idx_d   = '0;
            load    = 1'b1;
        end else if ((state_q == EMIT) && out_xfer) begin
            if (at_last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IW'(1);
                load  = 1'b1;
            end
        end
    end

    // Convert the lane that will be on the output after this edge
    assign lane_q   = word_d[idx_d*Q_DW +: Q_DW];
    assign m_last_d = last_d && (CW'(idx_d) == (cnt_d - CW'(1)));

    dequant_lane #(
        .Q_DW (Q_DW),
        .Q_PC (Q_PC),
        .A_DW (A_DW),
        .A_PC (A_PC)
    ) u_lane (
        .q_i (lane_q),
        .a_o (lane_a)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= CW'(LANES);
            last_q    <= 1'b0;
            word_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            word_q    <= word_d;
            m_valid_q <= (state_d == EMIT);
            if (load) begin
                m_data_q <= lane_a;
                m_last_q <= m_last_d;
            end else if (state_d == IDLE) begin
                m_last_q <= 1'b0;
            end
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;

endmodule

// File: doc/dequant_unpack.md
DEQUANT_UNPACK -- requirements
Module: dequant_unpack

Interface
REQ-001 SHALL have parameter Q_DW, default 8, meaning quantized element width (signed, Q4.3).
REQ-002 SHALL have parameter Q_PC, default 3, meaning quantized fraction bits.
REQ-003 SHALL have parameter A_DW, default 24, meaning expanded element width (signed, Q17.6).
REQ-004 SHALL have parameter A_PC, default 6, meaning expanded fraction bits; A_PC >= Q_PC.
REQ-005 SHALL have parameter LANES, default 4, meaning quantized elements per packed input word.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-008 SHALL have port s_valid, input, 1, meaning a packed word is offered.
REQ-009 SHALL have port s_ready, output, 1, meaning the block accepts the offered word this cycle.
REQ-010 SHALL have port s_data, input, LANES*Q_DW, meaning the packed word; lane 0 is in the LSBs.
REQ-011 SHALL have port s_cnt, input, clog2(LANES+1), meaning the number of valid lanes, starting from lane 0.
REQ-012 SHALL have port s_last, input, 1, meaning the word ends the tile.
REQ-013 SHALL have port m_valid, output, 1, meaning an expanded element is presented.
REQ-014 SHALL have port m_ready, input, 1, meaning the downstream accepts the element.
REQ-015 SHALL have port m_data, output, A_DW, meaning the expanded signed element.
REQ-016 SHALL have port m_last, output, 1, meaning the element is the final valid lane of an s_last word.

Function
REQ-017 SHALL transfer on the input side when s_valid && s_ready, and on the output side when m_valid && m_ready.
REQ-018 SHALL compute m_data as the sign-extended lane value shifted left by (A_PC-Q_PC); the conversion is exact, with no rounding and no saturation.
REQ-019 SHALL treat s_cnt == 0 or s_cnt > LANES as LANES.
REQ-020 SHALL use FSM states IDLE (no word held) and EMIT (word held, lane index idx valid).
REQ-021 SHALL move IDLE -> EMIT on an input transfer, capturing s_data, the effective count, s_last, and idx = 0.
REQ-022 SHALL, in EMIT, advance idx on each output transfer.
REQ-023 SHALL, on the output transfer of lane cnt-1, go to IDLE, or reload EMIT with idx = 0 if an input transfer occurs in the same cycle.
REQ-024 SHALL drive s_ready = (state == IDLE) || (m_valid && m_ready && idx == cnt-1), giving zero-bubble back-to-back words at one element per cycle.
REQ-025 SHALL drive m_data and m_last from a register, so latency from the input transfer to the first m_valid is 1 cycle.
REQ-026 SHALL hold m_valid, m_data and m_last stable while m_valid && !m_ready.
REQ-027 SHALL assert m_last only with lane cnt-1 of a word captured with s_last = 1.
REQ-028 SHALL NOT combinationally depend s_ready on s_valid.

Reset
REQ-029 SHALL, while rst_n = 0, force state = IDLE, idx = 0, m_valid = 0, m_data = 0, m_last = 0 and s_ready = 0, asynchronously.
REQ-030 SHALL discard a partially emitted word on reset, with no element of it appearing after rst_n rises.
REQ-031 SHALL assert s_ready on the first clk edge after reset release.

Structure
REQ-032 SHALL take Q_DW, Q_PC, A_DW, A_PC, LANES and the state enum from a shared package dq_pkg, which is also used by the quantizer side.
REQ-033 SHALL instantiate the combinational per-element conversion as sub-module dequant_lane, with one instance fed by the idx-selected lane.

Verification
REQ-034 SHALL verify: s_data = 0x80_7F_01_FF, s_cnt = 4, s_last = 1, m_ready = 1 -> m_data sequence 0xFFFFF8, 0x000008, 0x0003F8, 0xFFFC00 on consecutive cycles, with m_last on the 4th only.
REQ-035 SHALL verify: two words of s_cnt = 4 offered back-to-back, m_ready = 1 -> 8 outputs in 8 consecutive cycles, and s_ready high exactly on cycles 0 and 4.
REQ-036 SHALL verify: s_cnt = 2, s_data = 0xAA_BB_10_F0, s_last = 1 -> outputs 0xFFFF80 then 0x000080 (m_last = 1), and lanes 2-3 are never emitted.
REQ-037 SHALL verify: m_ready toggled randomly 50% over 100 words -> no data or m_last change while stalled, and element order and values match a reference model.
REQ-038 SHALL verify: rst_n asserted after 2 of 4 lanes are emitted -> m_valid = 0 immediately, and the next word after release emits from its lane 0.
REQ-039 SHALL verify: s_cnt = 0 -> behaves as s_cnt = 4.
